// File: rtl/bsg_upstream_link_serializer_if.sv
// Core-side handshake and channel-side bus of the upstream link serializer.
// Valid/ready: a word transfers in any cycle where core_valid_in & core_ready_out; ready never depends on valid.
interface bsg_upstream_link_serializer_if #(
    parameter int CORE_W = 64,
    parameter int CH_NUM = 2,
    parameter int CH_W   = 8
);
    logic [CORE_W-1:0]      core_data_in;
    logic                   core_valid_in;
    logic                   core_ready_out;
    logic                   io_token;
    logic                   io_valid_out;
    logic [CH_NUM*CH_W-1:0] io_data_out;
    logic [CH_NUM-1:0]      io_parity_out;

    modport master (
        output core_data_in, core_valid_in, io_token,
        input  core_ready_out, io_valid_out, io_data_out, io_parity_out
    );

    modport slave (
        input  core_data_in, core_valid_in, io_token,
        output core_ready_out, io_valid_out, io_data_out, io_parity_out
    );
endinterface

// File: rtl/bsg_upstream_link_serializer.sv
// Credit-flow-controlled serializer: one core word out as BEATS beats over CH_NUM channels.
// Optional per-channel even parity is enabled by defining BSG_UPSTREAM_LINK_PARITY_EN.
module bsg_upstream_link_serializer #(
    parameter  int CORE_W  = 64,
    parameter  int CH_NUM  = 2,
    parameter  int CH_W    = 8,
    parameter  int CREDITS = 16,
    localparam int BEAT_W  = CH_NUM * CH_W,
    localparam int BEATS   = CORE_W / BEAT_W,
    localparam int SENT_W  = $clog2(BEATS),
    localparam int CRED_W  = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    bsg_upstream_link_serializer_if.slave link,
    output logic [SENT_W-1:0] sent_cnt,
    output logic [6:0]        finish_cnt,
    output logic [CRED_W-1:0] credit_cnt,
    output logic              credit_overflow,
    output logic              fsm_state
);

    if ((CORE_W % BEAT_W) != 0 || BEATS < 2) begin : g_bad_cfg
        $error("CORE_W must be a multiple of CH_NUM*CH_W with at least two beats");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state, state_next;

    logic              last_beat;
    logic              accept;
    logic              load;
    logic [CORE_W-1:0] shreg, shreg_next;
    logic [BEAT_W-1:0] beat_next;
    logic              valid_q;
    logic [BEAT_W-1:0] data_q;

    assign last_beat           = (state == SEND) && (sent_cnt == SENT_W'(BEATS - 1));
    assign link.core_ready_out = (credit_cnt != '0) && ((state == IDLE) || last_beat);
    assign accept              = link.core_valid_in && link.core_ready_out;
    assign load                = accept || ((state == SEND) && !last_beat);
    assign link.io_valid_out   = valid_q;
    assign link.io_data_out    = data_q;
    assign fsm_state           = state;

    // shreg keeps the not-yet-sent beats of the current word, lowest beat at the bottom.
    always_comb begin
        state_next = state;
        beat_next  = shreg[BEAT_W-1:0];
        shreg_next = shreg >> BEAT_W;
        if (accept) begin
            state_next = SEND;
            beat_next  = link.core_data_in[BEAT_W-1:0];
            shreg_next = link.core_data_in >> BEAT_W;
        end else if (last_beat) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            sent_cnt   <= '0;
            finish_cnt <= '0;
        end else begin
            if (accept || (state == SEND)) shreg <= shreg_next;
            if (load) begin
                valid_q <= 1'b1;
                data_q  <= beat_next;
            end else if (last_beat) begin
                valid_q <= 1'b0;
            end
            if (accept || last_beat)  sent_cnt <= '0;
            else if (state == SEND)   sent_cnt <= sent_cnt + SENT_W'(1);
            if (last_beat) finish_cnt <= finish_cnt + 7'd1;
        end
    end

    // A token with the pool already full is lost; remember that it happened.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt      <= CRED_W'(CREDITS);
            credit_overflow <= 1'b0;
        end else begin
            case ({accept, link.io_token})
                2'b10: credit_cnt <= credit_cnt - CRED_W'(1);
                2'b01: begin
                    if (credit_cnt == CRED_W'(CREDITS)) credit_overflow <= 1'b1;
                    else                                credit_cnt <= credit_cnt + CRED_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef BSG_UPSTREAM_LINK_PARITY_EN
    logic [CH_NUM-1:0] par_q, par_next;

    always_comb begin
        par_next = '0;
        for (int c = 0; c < CH_NUM; c++) par_next[c] = ^beat_next[c*CH_W +: CH_W];
    end

    always_ff @(posedge clk) begin
        if (rst)       par_q <= '0;
        else if (load) par_q <= par_next;
    end

    assign link.io_parity_out = par_q;
`else
    assign link.io_parity_out = '0;
`endif

endmodule

// File: tb/tb_bsg_upstream_link_serializer.sv
// Directed bench for the upstream link serializer at default parameters (64b word, 2x8b channels, 16 credits).
module tb_bsg_upstream_link_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bsg_upstream_link_serializer_if #(.CORE_W(64), .CH_NUM(2), .CH_W(8)) link();

  logic [1:0] sent_cnt;
  logic [6:0] finish_cnt;
  logic [4:0] credit_cnt;
  logic       credit_overflow;
  logic       fsm_state;

  bsg_upstream_link_serializer dut (
    .clk             (clk),
    .rst             (rst),
    .link            (link),
    .sent_cnt        (sent_cnt),
    .finish_cnt      (finish_cnt),
    .credit_cnt      (credit_cnt),
    .credit_overflow (credit_overflow),
    .fsm_state       (fsm_state)
  );

  typedef struct {
    logic [63:0]       word;
    logic [3:0][15:0]  beats;
    logic [3:0][1:0]   par;
  } vec_t;

  vec_t        vecs[5];
  logic [15:0] exp_q[$];
  logic [63:0] b2b[3];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    link.core_valid_in = 1'b0;
    link.io_token = 1'b0;
    link.core_data_in = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (link.io_valid_out && n < 20) begin
      tick();
      n++;
    end
    check(name, link.io_valid_out, 1'b0);
  endtask

  task automatic send_one(input logic [63:0] w);
    link.core_data_in = w;
    link.core_valid_in = 1'b1;
    tick();
    link.core_valid_in = 1'b0;
  endtask

  function automatic logic [1:0] exp_par(input logic [1:0] p);
`ifdef BSG_UPSTREAM_LINK_PARITY_EN
    return p;
`else
    return 2'b00;
`endif
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    int idx;
    int valid_cycles;
    logic exp_rdy;

    vecs[0].word = 64'h0123_4567_89AB_CDEF;
    vecs[0].beats = {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    vecs[0].par = {2'b11, 2'b11, 2'b11, 2'b11};
    vecs[1].word = 64'h0000_0000_0000_00FF;
    vecs[1].beats = {16'h0000, 16'h0000, 16'h0000, 16'h00FF};
    vecs[1].par = {2'b00, 2'b00, 2'b00, 2'b00};
    vecs[2].word = 64'h0000_0000_0000_0001;
    vecs[2].beats = {16'h0000, 16'h0000, 16'h0000, 16'h0001};
    vecs[2].par = {2'b00, 2'b00, 2'b00, 2'b01};
    vecs[3].word = 64'hFFFF_0000_AAAA_8001;
    vecs[3].beats = {16'hFFFF, 16'h0000, 16'hAAAA, 16'h8001};
    vecs[3].par = {2'b00, 2'b00, 2'b00, 2'b11};
    vecs[4].word = 64'h1234_0700_00FE_5A5B;
    vecs[4].beats = {16'h1234, 16'h0700, 16'h00FE, 16'h5A5B};
    vecs[4].par = {2'b01, 2'b10, 2'b01, 2'b01};

    // reset values
    do_reset();
    check("rst_valid", link.io_valid_out, 1'b0);
    check("rst_data", link.io_data_out, 16'h0000);
    check("rst_parity", link.io_parity_out, 2'b00);
    check("rst_sent", sent_cnt, 2'd0);
    check("rst_finish", finish_cnt, 7'd0);
    check("rst_credit", credit_cnt, 5'd16);
    check("rst_overflow", credit_overflow, 1'b0);
    check("rst_state", fsm_state, 1'b0);
    check("rst_ready", link.core_ready_out, 1'b1);

    // single words from the vector table
    for (int i = 0; i < 5; i++) begin
      link.core_data_in = vecs[i].word;
      link.core_valid_in = 1'b1;
      check("vec_ready_idle", link.core_ready_out, 1'b1);
      tick();
      link.core_valid_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
        check("vec_valid", link.io_valid_out, 1'b1);
        check("vec_data", link.io_data_out, vecs[i].beats[k]);
        check("vec_parity", link.io_parity_out, exp_par(vecs[i].par[k]));
        check("vec_sent", sent_cnt, k);
        check("vec_ready_beat", link.core_ready_out, k == 3);
        tick();
      end
      check("vec_valid_end", link.io_valid_out, 1'b0);
      check("vec_data_hold", link.io_data_out, vecs[i].beats[3]);
      check("vec_finish", finish_cnt, i + 1);
      check("vec_credit", credit_cnt, 15 - i);
    end

    // back-to-back words with valid held
    do_reset();
    b2b[0] = 64'h1111_2222_3333_4444;
    b2b[1] = 64'hA5A5_5A5A_0F0F_F0F0;
    b2b[2] = 64'hDEAD_BEEF_CAFE_F00D;
    idx = 0;
    valid_cycles = 0;
    link.core_data_in = b2b[0];
    link.core_valid_in = 1'b1;
    for (int cyc = 0; cyc < 40 && !(idx == 3 && exp_q.size() == 0); cyc++) begin
      exp_rdy = (exp_q.size() <= 1);
      check("b2b_ready", link.core_ready_out, exp_rdy);
      if (link.io_valid_out) begin
        valid_cycles++;
        if (exp_q.size() > 0) check("b2b_beat", link.io_data_out, exp_q.pop_front());
        else check("b2b_extra_beat", link.io_valid_out, 1'b0);
      end else if (exp_q.size() > 0) begin
        check("b2b_gap", link.io_valid_out, 1'b1);
      end
      if (link.core_valid_in && exp_rdy) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(b2b[idx][k*16 +: 16]);
        idx++;
      end
      tick();
      if (idx < 3) link.core_data_in = b2b[idx];
      else link.core_valid_in = 1'b0;
    end
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_valid_cycles", valid_cycles, 12);
    check("b2b_finish", finish_cnt, 7'd3);

    // credit exhaustion
    do_reset();
    accepts = 0;
    link.core_data_in = 64'h0F1E_2D3C_4B5A_6978;
    link.core_valid_in = 1'b1;
    repeat (75) begin
      if (link.core_valid_in && link.core_ready_out) accepts++;
      tick();
    end
    check("cred_accepts", accepts, 16);
    check("cred_zero", credit_cnt, 5'd0);
    check("cred_ready_low", link.core_ready_out, 1'b0);
    check("cred_finish", finish_cnt, 7'd16);
    link.io_token = 1'b1;
    check("cred_token_cycle_ready", link.core_ready_out, 1'b0);
    tick();
    link.io_token = 1'b0;
    check("cred_after_token", credit_cnt, 5'd1);
    check("cred_ready_after_token", link.core_ready_out, 1'b1);
    tick();
    link.core_valid_in = 1'b0;
    check("cred_17th_credit", credit_cnt, 5'd0);
    check("cred_17th_valid", link.io_valid_out, 1'b1);
    check("cred_17th_data", link.io_data_out, 16'h6978);
    check("cred_17th_ready", link.core_ready_out, 1'b0);
    wait_idle("cred_idle");

    // simultaneous accept and token, then saturation
    do_reset();
    link.core_data_in = 64'h0000_0000_0000_1234;
    link.core_valid_in = 1'b1;
    link.io_token = 1'b1;
    tick();
    link.core_valid_in = 1'b0;
    link.io_token = 1'b0;
    check("simul_credit", credit_cnt, 5'd16);
    wait_idle("simul_idle");
    send_one(64'h5);
    check("simul_consume", credit_cnt, 5'd15);
    wait_idle("simul_idle2");
    link.io_token = 1'b1;
    tick();
    link.io_token = 1'b0;
    check("token_return", credit_cnt, 5'd16);
    check("token_no_ovf", credit_overflow, 1'b0);
    link.io_token = 1'b1;
    tick();
    link.io_token = 1'b0;
    check("sat_credit", credit_cnt, 5'd16);
    check("sat_overflow", credit_overflow, 1'b1);
    tick();
    tick();
    check("sat_sticky", credit_overflow, 1'b1);

    // reset in the middle of a word
    do_reset();
    send_one(64'h1);
    wait_idle("rmid_idle");
    check("rmid_finish_pre", finish_cnt, 7'd1);
    send_one(64'hFEDC_BA98_7654_3210);
    tick();
    tick();
    check("rmid_beat2", sent_cnt, 2'd2);
    check("rmid_beat2_data", link.io_data_out, 16'hBA98);
    rst = 1'b1;
    tick();
    check("rmid_valid", link.io_valid_out, 1'b0);
    check("rmid_credit", credit_cnt, 5'd16);
    check("rmid_sent", sent_cnt, 2'd0);
    check("rmid_finish", finish_cnt, 7'd0);
    check("rmid_state", fsm_state, 1'b0);
    rst = 1'b0;
    tick();

    // finish counter wrap
    do_reset();
    accepts = 0;
    link.core_data_in = 64'h8;
    link.core_valid_in = 1'b1;
    link.io_token = 1'b1;
    for (int cyc = 0; cyc < 1000 && accepts < 127; cyc++) begin
      if (link.core_valid_in && link.core_ready_out) accepts++;
      tick();
    end
    link.core_valid_in = 1'b0;
    link.io_token = 1'b0;
    check("wrap_accepts", accepts, 127);
    wait_idle("wrap_idle");
    check("wrap_127", finish_cnt, 7'd127);
    send_one(64'h9);
    wait_idle("wrap_idle2");
    check("wrap_0", finish_cnt, 7'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_upstream_link_serializer.md
# bsg_upstream_link_serializer

Parametrised upstream link transmitter. It accepts a wide word from the core through a valid/ready handshake and serialises it into beats across `CH_NUM` parallel output channels. Credit-based flow control uses returned `io_token` pulses. It replaces the fixed 64-bit, 2-channel, 2-cycle data-in path with configurable widths, channel count, credit depth and back-to-back word acceptance.

## Interface
Parameters:
- `CORE_W`, default 64: core word width.
- `CH_NUM`, default 2: number of output channels.
- `CH_W`, default 8: bits per channel per beat.
- `CREDITS`, default 16: credits available after reset (maximum outstanding words).
- Derived values:
  - `BEAT_W = CH_NUM*CH_W`
  - `BEATS = CORE_W/BEAT_W`
  - `CORE_W % BEAT_W == 0` and `BEATS >= 2` are required, checked by elaboration assertion.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `core_data_in`  in  CORE_W  word to send.
- `core_valid_in`  in  1  word valid.
- `core_ready_out`  out  1  word accepted when `core_valid_in & core_ready_out`.
- `io_token`  in  1  one-cycle pulse; returns one credit.
- `io_valid_out`  out  1  beat valid on channels.
- `io_data_out`  out  CH_NUM*CH_W  channel c occupies bits `[c*CH_W +: CH_W]`.
- `io_parity_out`  out  CH_NUM  per-channel parity (see Configuration).
- `sent_cnt`  out  clog2(BEATS)  index of the beat currently on the channels.
- `finish_cnt`  out  7  words completed, wraps modulo 128.
- `credit_cnt`  out  clog2(CREDITS+1)  available credits.
- `credit_overflow`  out  1  sticky error flag.

## Operation
- States:
  - IDLE: holding register empty.
  - SEND: serialising.
- Accept condition: `core_ready_out = (credit_cnt != 0) & (IDLE | (SEND & sent_cnt == BEATS-1))`. It is combinational from registered state only and never depends on `core_valid_in`.
- On accept:
  - latch `core_data_in` into the holding register;
  - consume one credit;
  - enter or stay in SEND;
  - set `sent_cnt` to 0 for the next cycle.
- Beat k carries word bits `[k*BEAT_W +: BEAT_W]`, lowest beat first. Within a beat, channel c carries beat bits `[c*CH_W +: CH_W]`.
- In SEND:
  - `sent_cnt` increments each cycle.
  - At `sent_cnt == BEATS-1`, `finish_cnt` increments, wrapping 127→0.
  - Without a new accept, the block returns to IDLE.
- Credits:
  - Each accept decrements `credit_cnt`; each `io_token` increments it.
  - Accept and token in the same cycle leave `credit_cnt` unchanged.
  - A token arriving with `credit_cnt == CREDITS` and no simultaneous accept is dropped. In that case `credit_cnt` saturates and `credit_overflow` is set until reset.
- With `credit_cnt == 0`, no word is accepted. A word already in SEND completes all its beats regardless of credits.
- `io_data_out` holds its last value while `io_valid_out` is 0.

## Timing
- Reset values:
  - state IDLE;
  - `io_valid_out` 0;
  - `io_data_out` 0;
  - `io_parity_out` 0;
  - `sent_cnt` 0;
  - `finish_cnt` 0;
  - `credit_cnt` = CREDITS;
  - `credit_overflow` 0.
- `rst` during SEND discards the in-flight word immediately. Partial beats are not completed, and consumed credits are restored to CREDITS.
- Accept in cycle t: beat 0 is on the channels with `io_valid_out = 1` in cycle t+1, and beat BEATS-1 in cycle t+BEATS.
- Back-to-back: an accept in the last-beat cycle puts beat 0 of the next word on the channels in the following cycle, with no bubble.
- `io_valid_out`, `io_data_out`, `io_parity_out`, `sent_cnt` and `finish_cnt` are registered.
- A token in cycle t is visible in `credit_cnt` and in `core_ready_out` at t+1.

## Configuration
- `BSG_UPSTREAM_LINK_PARITY_EN` defined:
  - `io_parity_out[c]` is the XOR of channel c bits of the same beat (even parity);
  - it is registered together with `io_data_out`.
- Not defined: `io_parity_out` is tied to 0 and no parity logic is present.

## Test plan
- **Single word.** Stimulus: defaults; after reset, send `0x0123456789ABCDEF`.
  - Required: `io_valid_out` for 4 cycles.
  - `io_data_out` sequence `0xCDEF`, `0x89AB`, `0x4567`, `0x0123`.
  - `finish_cnt` = 1 and `credit_cnt` = 15 afterwards.
- **Back-to-back.** Stimulus: 3 words with `core_valid_in` held.
  - Required: 12 consecutive valid beats with no gap.
  - `core_ready_out` high only in IDLE and in last-beat cycles.
- **Credit exhaustion.** Stimulus: 17 words, no tokens.
  - Required: 16 words accepted; `core_ready_out` stays 0 with `credit_cnt` = 0.
  - One `io_token` → 17th word accepted 1 cycle later.
- **Simultaneous accept and token.** Stimulus: accept and `io_token` in the same cycle.
  - Required: `credit_cnt` unchanged.
  - Also: token at `credit_cnt` = 16 with no accept → stays 16, `credit_overflow` = 1.
- **Reset mid-word.** Stimulus: assert `rst` during beat 2.
  - Required: next cycle `io_valid_out` = 0, `credit_cnt` = 16, `sent_cnt` = 0, `finish_cnt` = 0.
- **Parity and wrap.** Stimulus: with `BSG_UPSTREAM_LINK_PARITY_EN`, send `0x00000000000000FF` and `0x0000000000000001`.
  - Required: beat 0 parity `2'b00`, then `2'b01`.
  - Separately, 128 words → `finish_cnt` wraps to 0.
